// File: rtl/ysyx_24090012_bus_pkg.sv
// Shared bus definitions for the ysyx_24090012 core: AXI field widths,
// CLINT address window defaults, response codes and crossbar FSM encodings.
package ysyx_24090012_bus_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    localparam logic [ADDR_W-1:0] CLINT_BASE_DEF = 32'h0200_0000;
    localparam logic [ADDR_W-1:0] CLINT_MASK_DEF = 32'hFFFF_0000;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_S0   = 2'd1,
        R_S1   = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_S0   = 2'd1,
        W_S1   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ysyx_24090012_xbar_decode.sv
// Address-to-slave decoder for the crossbar.
// Ports: addr (in)  - request address
//        sel_clint (out) - 1 when addr falls in the CLINT window, else slave 0
module ysyx_24090012_xbar_decode
    import ysyx_24090012_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              sel_clint
);

    assign sel_clint = ((addr & CLINT_MASK) == CLINT_BASE);

endmodule

// File: rtl/ysyx_24090012_xbar.sv
// AXI4 1-to-2 crossbar: routes the arbiter's master port to the SoC bus
// (slave 0) or the CLINT (slave 1) by address. Independent read and write
// FSMs, one transaction in flight per direction.
// Ports: clk/rst (async active-high); m_* upstream master channels;
//        s0_*/s1_* downstream slave channels with identical port sets.
module ysyx_24090012_xbar
    import ysyx_24090012_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    // master side
    input  logic                m_awvalid,
    output logic                m_awready,
    input  logic [ADDR_W-1:0]   m_awaddr,
    input  logic [ID_W-1:0]     m_awid,
    input  logic [LEN_W-1:0]    m_awlen,
    input  logic [SIZE_W-1:0]   m_awsize,
    input  logic [BURST_W-1:0]  m_awburst,
    input  logic                m_wvalid,
    output logic                m_wready,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [STRB_W-1:0]   m_wstrb,
    input  logic                m_wlast,
    output logic                m_bvalid,
    input  logic                m_bready,
    output logic [RESP_W-1:0]   m_bresp,
    output logic [ID_W-1:0]     m_bid,
    input  logic                m_arvalid,
    output logic                m_arready,
    input  logic [ADDR_W-1:0]   m_araddr,
    input  logic [ID_W-1:0]     m_arid,
    input  logic [LEN_W-1:0]    m_arlen,
    input  logic [SIZE_W-1:0]   m_arsize,
    input  logic [BURST_W-1:0]  m_arburst,
    output logic                m_rvalid,
    input  logic                m_rready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [RESP_W-1:0]   m_rresp,
    output logic                m_rlast,
    output logic [ID_W-1:0]     m_rid,
    // slave 0 (SoC bus)
    output logic                s0_awvalid,
    input  logic                s0_awready,
    output logic [ADDR_W-1:0]   s0_awaddr,
    output logic [ID_W-1:0]     s0_awid,
    output logic [LEN_W-1:0]    s0_awlen,
    output logic [SIZE_W-1:0]   s0_awsize,
    output logic [BURST_W-1:0]  s0_awburst,
    output logic                s0_wvalid,
    input  logic                s0_wready,
    output logic [DATA_W-1:0]   s0_wdata,
    output logic [STRB_W-1:0]   s0_wstrb,
    output logic                s0_wlast,
    input  logic                s0_bvalid,
    output logic                s0_bready,
    input  logic [RESP_W-1:0]   s0_bresp,
    input  logic [ID_W-1:0]     s0_bid,
    output logic                s0_arvalid,
    input  logic                s0_arready,
    output logic [ADDR_W-1:0]   s0_araddr,
    output logic [ID_W-1:0]     s0_arid,
    output logic [LEN_W-1:0]    s0_arlen,
    output logic [SIZE_W-1:0]   s0_arsize,
    output logic [BURST_W-1:0]  s0_arburst,
    input  logic                s0_rvalid,
    output logic                s0_rready,
    input  logic [DATA_W-1:0]   s0_rdata,
    input  logic [RESP_W-1:0]   s0_rresp,
    input  logic                s0_rlast,
    input  logic [ID_W-1:0]     s0_rid,
    // slave 1 (CLINT)
    output logic                s1_awvalid,
    input  logic                s1_awready,
    output logic [ADDR_W-1:0]   s1_awaddr,
    output logic [ID_W-1:0]     s1_awid,
    output logic [LEN_W-1:0]    s1_awlen,
    output logic [SIZE_W-1:0]   s1_awsize,
    output logic [BURST_W-1:0]  s1_awburst,
    output logic                s1_wvalid,
    input  logic                s1_wready,
    output logic [DATA_W-1:0]   s1_wdata,
    output logic [STRB_W-1:0]   s1_wstrb,
    output logic                s1_wlast,
    input  logic                s1_bvalid,
    output logic                s1_bready,
    input  logic [RESP_W-1:0]   s1_bresp,
    input  logic [ID_W-1:0]     s1_bid,
    output logic                s1_arvalid,
    input  logic                s1_arready,
    output logic [ADDR_W-1:0]   s1_araddr,
    output logic [ID_W-1:0]     s1_arid,
    output logic [LEN_W-1:0]    s1_arlen,
    output logic [SIZE_W-1:0]   s1_arsize,
    output logic [BURST_W-1:0]  s1_arburst,
    input  logic                s1_rvalid,
    output logic                s1_rready,
    input  logic [DATA_W-1:0]   s1_rdata,
    input  logic [RESP_W-1:0]   s1_rresp,
    input  logic                s1_rlast,
    input  logic [ID_W-1:0]     s1_rid
);

    rd_state_e r_state_q, r_state_d;
    wr_state_e w_state_q, w_state_d;
    logic      ar_hit;
    logic      aw_hit;

    ysyx_24090012_xbar_decode #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_MASK (CLINT_MASK)
    ) u_ar_dec (
        .addr      (m_araddr),
        .sel_clint (ar_hit)
    );

    ysyx_24090012_xbar_decode #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_MASK (CLINT_MASK)
    ) u_aw_dec (
        .addr      (m_awaddr),
        .sel_clint (aw_hit)
    );

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
        end
    end

    // Read FSM: decode in IDLE, then pass AR/R through until the last beat
    always_comb begin
        r_state_d  = r_state_q;
        s0_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_arvalid = 1'b0;
        s1_rready  = 1'b0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (m_arvalid) r_state_d = ar_hit ? R_S1 : R_S0;
            end
            R_S0: begin
                s0_arvalid = m_arvalid;
                m_arready  = s0_arready;
                s0_rready  = m_rready;
                m_rvalid   = s0_rvalid;
                if (s0_rvalid && m_rready && s0_rlast) r_state_d = R_IDLE;
            end
            R_S1: begin
                s1_arvalid = m_arvalid;
                m_arready  = s1_arready;
                s1_rready  = m_rready;
                m_rvalid   = s1_rvalid;
                if (s1_rvalid && m_rready && s1_rlast) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM: decode in IDLE, then pass AW/W/B through until the B handshake
    always_comb begin
        w_state_d  = w_state_q;
        s0_awvalid = 1'b0;
        s0_wvalid  = 1'b0;
        s0_bready  = 1'b0;
        s1_awvalid = 1'b0;
        s1_wvalid  = 1'b0;
        s1_bready  = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (m_awvalid) w_state_d = aw_hit ? W_S1 : W_S0;
            end
            W_S0: begin
                s0_awvalid = m_awvalid;
                m_awready  = s0_awready;
                s0_wvalid  = m_wvalid;
                m_wready   = s0_wready;
                s0_bready  = m_bready;
                m_bvalid   = s0_bvalid;
                if (s0_bvalid && m_bready) w_state_d = W_IDLE;
            end
            W_S1: begin
                s1_awvalid = m_awvalid;
                m_awready  = s1_awready;
                s1_wvalid  = m_wvalid;
                m_wready   = s1_wready;
                s1_bready  = m_bready;
                m_bvalid   = s1_bvalid;
                if (s1_bvalid && m_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Response payloads follow the active slave; slave 0 when idle
    assign m_rdata = (r_state_q == R_S1) ? s1_rdata : s0_rdata;
    assign m_rresp = (r_state_q == R_S1) ? s1_rresp : s0_rresp;
    assign m_rlast = (r_state_q == R_S1) ? s1_rlast : s0_rlast;
    assign m_rid   = (r_state_q == R_S1) ? s1_rid   : s0_rid;
    assign m_bresp = (w_state_q == W_S1) ? s1_bresp : s0_bresp;
    assign m_bid   = (w_state_q == W_S1) ? s1_bid   : s0_bid;

    // Request payloads fan out to both slaves; only the valids are steered
    assign s0_awaddr  = m_awaddr;
    assign s0_awid    = m_awid;
    assign s0_awlen   = m_awlen;
    assign s0_awsize  = m_awsize;
    assign s0_awburst = m_awburst;
    assign s0_wdata   = m_wdata;
    assign s0_wstrb   = m_wstrb;
    assign s0_wlast   = m_wlast;
    assign s0_araddr  = m_araddr;
    assign s0_arid    = m_arid;
    assign s0_arlen   = m_arlen;
    assign s0_arsize  = m_arsize;
    assign s0_arburst = m_arburst;
    assign s1_awaddr  = m_awaddr;
    assign s1_awid    = m_awid;
    assign s1_awlen   = m_awlen;
    assign s1_awsize  = m_awsize;
    assign s1_awburst = m_awburst;
    assign s1_wdata   = m_wdata;
    assign s1_wstrb   = m_wstrb;
    assign s1_wlast   = m_wlast;
    assign s1_araddr  = m_araddr;
    assign s1_arid    = m_arid;
    assign s1_arlen   = m_arlen;
    assign s1_arsize  = m_arsize;
    assign s1_arburst = m_arburst;

endmodule
